spi_shader_loader: RTL

//  SPI initiator that drives the tiny shader's SPI receiver: writes command bytes and shader programs.

---
 rtl/spi_shader_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_shader_loader.sv
// SPI initiator (CPOL=0, CPHA=1, MSB first) that turns a valid/ready byte stream into
// chip-select framed transfers for the shader receiver and returns the MISO bytes.
module spi_shader_loader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_mode_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_cs_o,
  output logic       mode_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned GapW = $clog2(CS_GAP + 1);
  localparam logic [DivW-1:0] DivLoad  = DivW'(CLK_DIV);
  localparam logic [DivW-1:0] DivEarly = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne   = DivW'(1);
  localparam logic [GapW-1:0] GapLoad  = GapW'(CS_GAP);
  localparam logic [GapW-1:0] GapOne   = GapW'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StLead, StTrail, StWait, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            mosi_q, mosi_d;
  logic            mode_q, mode_d;
  logic            last_q, last_d;
  logic            mid_frame_byte_end;

  // Between bytes of a frame, the bit-0 TRAIL is shortened by one cycle so that the WAIT
  // accept cycle completes the byte slot; an unstalled frame then keeps 16*CLK_DIV per byte.
  assign mid_frame_byte_end = (bit_q == 3'd0) && !last_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    mode_d     = mode_q;
    last_d     = last_q;
    unique case (state_q)
      StIdle: begin
        if (tx_valid_i) begin
          state_d = StSetup;
          div_d   = DivLoad;
          tx_sh_d = tx_data_i;
          last_d  = tx_last_i;
          mode_d  = tx_mode_i;
          bit_d   = 3'd7;
        end
      end
      StSetup: begin
        if (div_q == DivOne) begin
          state_d = StLead;
          div_d   = DivLoad;
          mosi_d  = tx_sh_q[7];
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StLead: begin
        if (div_q == DivOne) begin
          rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
          if (mid_frame_byte_end && (CLK_DIV == 32'd1)) begin
            state_d    = StWait;
            bit_d      = 3'd7;
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sh_q[6:0], spi_miso_i};
          end else begin
            state_d = StTrail;
            div_d   = mid_frame_byte_end ? DivEarly : DivLoad;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StTrail: begin
        if (div_q == DivOne) begin
          bit_d = bit_q - 3'd1;
          div_d = DivLoad;
          if (bit_q == 3'd0) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            state_d    = last_q ? StHold : StWait;
          end else begin
            state_d = StLead;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StWait: begin
        if (tx_valid_i) begin
          state_d = StLead;
          div_d   = DivLoad;
          tx_sh_d = tx_data_i;
          last_d  = tx_last_i;
          mosi_d  = tx_data_i[7];
        end
      end
      StHold: begin
        if (div_q == DivOne) begin
          state_d = StGap;
          gap_d   = GapLoad;
          mosi_d  = 1'b0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StGap: begin
        mosi_d = 1'b0;
        if (gap_q == GapOne) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StGap;
      div_q      <= '0;
      gap_q      <= GapLoad;
      bit_q      <= 3'd7;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
    end
  end

  assign tx_ready_o = (state_q == StIdle) || (state_q == StWait);
  assign busy_o     = (state_q != StIdle);
  assign spi_cs_o   = (state_q == StIdle) || (state_q == StGap);
  assign spi_sclk_o = (state_q == StLead);
  assign spi_mosi_o = mosi_q;
  assign mode_o     = mode_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
